// File: rtl/cache_fill_fsm.sv
`default_nettype none
// cache_fill_fsm: block-fill initiator for a pipelined memory port; also forwards write-through stores when idle.
// Revision 1.0 - initial release

module cache_fill_fsm #(
   parameter int ADDR_WIDTH  = 16,
   parameter int OFFSET_BITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_detected,
   input  logic [ADDR_WIDTH-1:0]  miss_address,
   input  logic                   store_req,
   input  logic [ADDR_WIDTH-1:0]  store_addr,
   input  logic [15:0]            store_data,
   input  logic                   memory_data_valid,
   input  logic [15:0]            memory_data,
   output logic                   fsm_busy,
   output logic                   store_accept,
   output logic                   mem_enable,
   output logic                   mem_wr,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   output logic [15:0]            mem_data_in,
   output logic                   write_data_array,
   output logic [OFFSET_BITS-1:0] fill_word_offset,
   output logic [15:0]            fill_data,
   output logic                   write_tag_array,
   output logic [ADDR_WIDTH-1:0]  fill_base,
   output logic                   fill_done
);

   localparam int CW = OFFSET_BITS + 1;
   localparam logic [CW-1:0] WORDS = CW'(1 << OFFSET_BITS);
   localparam logic [CW-1:0] LAST  = CW'((1 << OFFSET_BITS) - 1);
   // Clears the word offset and the byte-within-word bit.
   localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((1 << CW) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   base_reg, base_next;
   logic [CW-1:0]           req_cnt, req_next;
   logic [CW-1:0]           rcv_cnt, rcv_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         base_reg <= '0;
         req_cnt  <= '0;
         rcv_cnt  <= '0;
      end else begin
         state    <= state_next;
         base_reg <= base_next;
         req_cnt  <= req_next;
         rcv_cnt  <= rcv_next;
      end
   end

   always_comb begin
      state_next       = state;
      base_next        = base_reg;
      req_next         = req_cnt;
      rcv_next         = rcv_cnt;
      mem_enable       = 1'b0;
      mem_wr           = 1'b0;
      mem_address      = '0;
      mem_data_in      = '0;
      store_accept     = 1'b0;
      write_data_array = 1'b0;
      fill_word_offset = '0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;

      // Everything is held quiet while rst is asserted, including a mid-fill reset.
      if (!rst) begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  base_next  = miss_address & BLOCK_MASK;
                  req_next   = '0;
                  rcv_next   = '0;
                  state_next = REQ;
               end else if (store_req) begin
                  mem_enable   = 1'b1;
                  mem_wr       = 1'b1;
                  mem_address  = store_addr;
                  mem_data_in  = store_data;
                  store_accept = 1'b1;
               end
            end
            REQ: begin
               mem_enable  = 1'b1;
               mem_address = base_reg | ADDR_WIDTH'({req_cnt[OFFSET_BITS-1:0], 1'b0});
               req_next    = req_cnt + 1'b1;
               if (req_cnt == LAST) begin
                  state_next = WAIT;
               end
            end
            WAIT: begin
            end
            default: state_next = IDLE;
         endcase

         // Responses come back in issue order, so the receive count is the word index.
         if ((state != IDLE) && memory_data_valid && (rcv_cnt < WORDS)) begin
            write_data_array = 1'b1;
            fill_word_offset = rcv_cnt[OFFSET_BITS-1:0];
            rcv_next         = rcv_cnt + 1'b1;
            if (rcv_cnt == LAST) begin
               write_tag_array = 1'b1;
               fill_done       = 1'b1;
               state_next      = IDLE;
            end
         end
      end
   end

   assign fsm_busy  = !rst && (state != IDLE);
   assign fill_data = rst ? '0 : memory_data;
   assign fill_base = rst ? '0 : base_reg;

endmodule

`default_nettype wire
